// File: rtl/mem_bus_arbiter.sv
// Shared memory port arbiter for fetch, data-read and data-write requesters.
// Fixed priority write > read > fetch, with fetch anti-starvation and an ack timeout.
module mem_bus_arbiter #(
  parameter int ACK_TIMEOUT  = 255,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_read_req,
  input  logic        i_read_w,
  input  logic        i_read_hw,
  input  logic [31:0] i_read_adr,
  input  logic        d_read_req,
  input  logic        d_read_w,
  input  logic        d_read_hw,
  input  logic [31:0] d_read_adr,
  input  logic        d_write_req,
  input  logic        d_write_w,
  input  logic        d_write_hw,
  input  logic [31:0] d_write_adr,
  input  logic [31:0] d_write_data,
  output logic        read_valid,
  output logic [31:0] read_data,
  output logic        write_finish,
  output logic        bus_err,
  output logic [1:0]  grant_id,
  output logic        m_req,
  output logic        m_we,
  output logic        m_w,
  output logic        m_hw,
  output logic [31:0] m_adr,
  output logic [31:0] m_wdata,
  input  logic        m_ack,
  input  logic [31:0] m_rdata
);

  // state | meaning
  // IDLE  | no transaction; arbitrate among pending requests
  // BUSY  | m_req held, waiting for m_ack or timeout
  // DONE  | completion pulses visible; requester may drop its request
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [7:0] TO_LAST    = 8'(ACK_TIMEOUT - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t      state, state_nx;
  logic [7:0]  to_cnt, to_cnt_nx;
  logic [3:0]  starve_cnt, starve_nx;
  logic        read_valid_nx, write_finish_nx, bus_err_nx;
  logic [31:0] read_data_nx;
  logic [1:0]  grant_id_nx;
  logic        m_req_nx, m_we_nx, m_w_nx, m_hw_nx;
  logic [31:0] m_adr_nx, m_wdata_nx;
  logic        fetch_force;

  assign fetch_force = (starve_cnt == STARVE_MAX) && i_read_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      to_cnt       <= '0;
      starve_cnt   <= '0;
      read_valid   <= 1'b0;
      write_finish <= 1'b0;
      bus_err      <= 1'b0;
      read_data    <= '0;
      grant_id     <= 2'b00;
      m_req        <= 1'b0;
      m_we         <= 1'b0;
      m_w          <= 1'b0;
      m_hw         <= 1'b0;
      m_adr        <= '0;
      m_wdata      <= '0;
    end else begin
      state        <= state_nx;
      to_cnt       <= to_cnt_nx;
      starve_cnt   <= starve_nx;
      read_valid   <= read_valid_nx;
      write_finish <= write_finish_nx;
      bus_err      <= bus_err_nx;
      read_data    <= read_data_nx;
      grant_id     <= grant_id_nx;
      m_req        <= m_req_nx;
      m_we         <= m_we_nx;
      m_w          <= m_w_nx;
      m_hw         <= m_hw_nx;
      m_adr        <= m_adr_nx;
      m_wdata      <= m_wdata_nx;
    end
  end

  always_comb begin
    state_nx        = state;
    to_cnt_nx       = to_cnt;
    starve_nx       = starve_cnt;
    read_valid_nx   = 1'b0;
    write_finish_nx = 1'b0;
    bus_err_nx      = 1'b0;
    read_data_nx    = read_data;
    grant_id_nx     = grant_id;
    m_req_nx        = m_req;
    m_we_nx         = m_we;
    m_w_nx          = m_w;
    m_hw_nx         = m_hw;
    m_adr_nx        = m_adr;
    m_wdata_nx      = m_wdata;

    case (state)
      IDLE: begin
        if (i_read_req || d_read_req || d_write_req) begin
          m_req_nx  = 1'b1;
          to_cnt_nx = '0;
          state_nx  = BUSY;
          if (fetch_force || !(d_write_req || d_read_req)) begin
            grant_id_nx = 2'b01;
            m_we_nx     = 1'b0;
            m_w_nx      = i_read_w;
            m_hw_nx     = i_read_hw;
            m_adr_nx    = i_read_adr;
            starve_nx   = '0;
          end else begin
            if (d_write_req) begin
              grant_id_nx = 2'b11;
              m_we_nx     = 1'b1;
              m_w_nx      = d_write_w;
              m_hw_nx     = d_write_hw;
              m_adr_nx    = d_write_adr;
              m_wdata_nx  = d_write_data;
            end else begin
              grant_id_nx = 2'b10;
              m_we_nx     = 1'b0;
              m_w_nx      = d_read_w;
              m_hw_nx     = d_read_hw;
              m_adr_nx    = d_read_adr;
            end
            if (i_read_req && starve_cnt < STARVE_MAX)
              starve_nx = starve_cnt + 4'd1;
          end
        end
      end
      BUSY: begin
        // An ack in the final timeout cycle wins over the timeout.
        if (m_ack || to_cnt == TO_LAST) begin
          m_req_nx   = 1'b0;
          bus_err_nx = !m_ack;
          state_nx   = DONE;
          if (m_we) begin
            write_finish_nx = 1'b1;
          end else begin
            read_valid_nx = 1'b1;
            read_data_nx  = m_ack ? m_rdata : 32'h0;
          end
        end else begin
          to_cnt_nx = to_cnt + 8'd1;
        end
      end
      DONE: begin
        grant_id_nx = 2'b00;
        state_nx    = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (ACK_TIMEOUT=8, STARVE_LIMIT=2).
// Inputs change and outputs are sampled on the falling edge.
module tb_mem_bus_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        i_read_req, i_read_w, i_read_hw;
  logic [31:0] i_read_adr;
  logic        d_read_req, d_read_w, d_read_hw;
  logic [31:0] d_read_adr;
  logic        d_write_req, d_write_w, d_write_hw;
  logic [31:0] d_write_adr, d_write_data;
  logic        read_valid, write_finish, bus_err;
  logic [31:0] read_data;
  logic [1:0]  grant_id;
  logic        m_req, m_we, m_w, m_hw;
  logic [31:0] m_adr, m_wdata;
  logic        m_ack;
  logic [31:0] m_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ACK_TIMEOUT(8), .STARVE_LIMIT(2)) dut (
    .clk(clk), .rst(rst),
    .i_read_req(i_read_req), .i_read_w(i_read_w), .i_read_hw(i_read_hw), .i_read_adr(i_read_adr),
    .d_read_req(d_read_req), .d_read_w(d_read_w), .d_read_hw(d_read_hw), .d_read_adr(d_read_adr),
    .d_write_req(d_write_req), .d_write_w(d_write_w), .d_write_hw(d_write_hw),
    .d_write_adr(d_write_adr), .d_write_data(d_write_data),
    .read_valid(read_valid), .read_data(read_data), .write_finish(write_finish),
    .bus_err(bus_err), .grant_id(grant_id),
    .m_req(m_req), .m_we(m_we), .m_w(m_w), .m_hw(m_hw), .m_adr(m_adr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata)
  );

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({m_req, m_we, m_w, m_hw, read_valid, write_finish, bus_err} !== 7'b0) begin
      failures++; $display("FAIL reset_ctrl got %b exp 0", {m_req, m_we, m_w, m_hw, read_valid, write_finish, bus_err});
    end
    checks++;
    if ({m_adr, m_wdata, read_data, grant_id} !== 98'b0) begin
      failures++; $display("FAIL reset_data got adr=%h wdata=%h rdata=%h gid=%b exp 0", m_adr, m_wdata, read_data, grant_id);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_fetch();
    i_read_req = 1'b1; i_read_w = 1'b1; i_read_adr = 32'h100;
    @(negedge clk);
    checks++;
    if (m_req !== 1'b1 || m_adr !== 32'h100 || m_we !== 1'b0 || m_w !== 1'b1 || grant_id !== 2'b01) begin
      failures++; $display("FAIL fetch_grant got req=%b adr=%h we=%b w=%b gid=%b exp 1/100/0/1/01", m_req, m_adr, m_we, m_w, grant_id);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (read_valid !== 1'b0 || m_req !== 1'b1 || grant_id !== 2'b01) begin
      failures++; $display("FAIL fetch_wait got rv=%b req=%b gid=%b exp 0/1/01", read_valid, m_req, grant_id);
    end
    m_ack = 1'b1; m_rdata = 32'hDEADBEEF;
    @(negedge clk);
    m_ack = 1'b0; m_rdata = 32'h0; i_read_req = 1'b0;
    checks++;
    if (read_valid !== 1'b1 || read_data !== 32'hDEADBEEF || m_req !== 1'b0 || bus_err !== 1'b0) begin
      failures++; $display("FAIL fetch_done got rv=%b rd=%h req=%b err=%b exp 1/deadbeef/0/0", read_valid, read_data, m_req, bus_err);
    end
    @(negedge clk);
    checks++;
    if (read_valid !== 1'b0 || grant_id !== 2'b00 || read_data !== 32'hDEADBEEF) begin
      failures++; $display("FAIL fetch_idle got rv=%b gid=%b rd=%h exp 0/00/deadbeef", read_valid, grant_id, read_data);
    end
  endtask

  task automatic test_write_then_read();
    d_write_req = 1'b1; d_write_adr = 32'h200; d_write_data = 32'h55; d_write_w = 1'b1;
    d_read_req = 1'b1; d_read_adr = 32'h204;
    @(negedge clk);
    checks++;
    if (grant_id !== 2'b11 || m_we !== 1'b1 || m_adr !== 32'h200 || m_wdata !== 32'h55) begin
      failures++; $display("FAIL wr_grant got gid=%b we=%b adr=%h wd=%h exp 11/1/200/55", grant_id, m_we, m_adr, m_wdata);
    end
    m_ack = 1'b1;
    @(negedge clk);
    m_ack = 1'b0; d_write_req = 1'b0;
    checks++;
    if (write_finish !== 1'b1 || read_valid !== 1'b0) begin
      failures++; $display("FAIL wr_done got wf=%b rv=%b exp 1/0", write_finish, read_valid);
    end
    @(negedge clk);
    checks++;
    if (write_finish !== 1'b0 || grant_id !== 2'b00 || m_req !== 1'b0) begin
      failures++; $display("FAIL wr_idle got wf=%b gid=%b req=%b exp 0/00/0", write_finish, grant_id, m_req);
    end
    @(negedge clk);
    checks++;
    if (grant_id !== 2'b10 || m_we !== 1'b0 || m_adr !== 32'h204 || m_req !== 1'b1) begin
      failures++; $display("FAIL rd_grant got gid=%b we=%b adr=%h req=%b exp 10/0/204/1", grant_id, m_we, m_adr, m_req);
    end
    m_ack = 1'b1; m_rdata = 32'h1234;
    @(negedge clk);
    m_ack = 1'b0; d_read_req = 1'b0;
    checks++;
    if (read_valid !== 1'b1 || read_data !== 32'h1234 || write_finish !== 1'b0) begin
      failures++; $display("FAIL rd_done got rv=%b rd=%h wf=%b exp 1/1234/0", read_valid, read_data, write_finish);
    end
    @(negedge clk);
    checks++;
    if (read_valid !== 1'b0 || write_finish !== 1'b0) begin
      failures++; $display("FAIL rd_single got rv=%b wf=%b exp 0/0", read_valid, write_finish);
    end
  endtask

  task automatic test_starvation();
    logic [1:0] exp_order [4];
    exp_order[0] = 2'b10; exp_order[1] = 2'b10; exp_order[2] = 2'b01; exp_order[3] = 2'b10;
    i_read_req = 1'b1; i_read_adr = 32'h180; d_read_req = 1'b1; d_read_adr = 32'h280;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      checks++;
      if (grant_id !== exp_order[t]) begin
        failures++; $display("FAIL starve_order[%0d] got %b exp %b", t, grant_id, exp_order[t]);
      end
      m_ack = 1'b1; m_rdata = 32'hA0 + t;
      @(negedge clk);
      m_ack = 1'b0;
      @(negedge clk);
      if (t == 3) begin
        i_read_req = 1'b0; d_read_req = 1'b0;
      end
    end
    @(negedge clk);
    checks++;
    if (m_req !== 1'b0 || grant_id !== 2'b00) begin
      failures++; $display("FAIL starve_quiet got req=%b gid=%b exp 0/00", m_req, grant_id);
    end
  endtask

  task automatic test_timeout();
    int  cnt = 0;
    bit  done = 0;
    d_read_req = 1'b1; d_read_adr = 32'h300;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (m_req === 1'b1) cnt++;
      else if (cnt > 0) done = 1;
    end
    d_read_req = 1'b0;
    checks++;
    if (!done || cnt != 8) begin
      failures++; $display("FAIL timeout_len got done=%0d cycles=%0d exp 1/8", done, cnt);
    end
    checks++;
    if (bus_err !== 1'b1 || read_valid !== 1'b1 || read_data !== 32'h0) begin
      failures++; $display("FAIL timeout_done got err=%b rv=%b rd=%h exp 1/1/0", bus_err, read_valid, read_data);
    end
    @(negedge clk);
    @(negedge clk);
    m_ack = 1'b1; m_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    m_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (read_valid !== 1'b0 || write_finish !== 1'b0 || bus_err !== 1'b0 || read_data !== 32'h0 || grant_id !== 2'b00) begin
      failures++; $display("FAIL late_ack got rv=%b wf=%b err=%b rd=%h gid=%b exp 0/0/0/0/00", read_valid, write_finish, bus_err, read_data, grant_id);
    end
  endtask

  task automatic test_ack_last_cycle();
    i_read_req = 1'b1; i_read_adr = 32'h400;
    repeat (8) @(negedge clk);
    checks++;
    if (m_req !== 1'b1 || grant_id !== 2'b01) begin
      failures++; $display("FAIL last_cycle_req got req=%b gid=%b exp 1/01", m_req, grant_id);
    end
    m_ack = 1'b1; m_rdata = 32'hCAFE0001;
    @(negedge clk);
    m_ack = 1'b0; i_read_req = 1'b0;
    checks++;
    if (read_valid !== 1'b1 || bus_err !== 1'b0 || read_data !== 32'hCAFE0001) begin
      failures++; $display("FAIL last_cycle_ack got rv=%b err=%b rd=%h exp 1/0/cafe0001", read_valid, bus_err, read_data);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_busy();
    d_write_req = 1'b1; d_write_adr = 32'h600; d_write_data = 32'h77;
    @(negedge clk);
    checks++;
    if (m_req !== 1'b1 || grant_id !== 2'b11) begin
      failures++; $display("FAIL rb_grant got req=%b gid=%b exp 1/11", m_req, grant_id);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (m_req !== 1'b0 || grant_id !== 2'b00 || m_we !== 1'b0 || m_adr !== 32'h0 || m_wdata !== 32'h0 || read_data !== 32'h0) begin
      failures++; $display("FAIL rb_async got req=%b gid=%b we=%b adr=%h wd=%h rd=%h exp all 0", m_req, grant_id, m_we, m_adr, m_wdata, read_data);
    end
    d_write_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (write_finish !== 1'b0 || m_req !== 1'b0) begin
      failures++; $display("FAIL rb_no_completion got wf=%b req=%b exp 0/0", write_finish, m_req);
    end
    i_read_req = 1'b1; i_read_adr = 32'h500;
    @(negedge clk);
    checks++;
    if (m_req !== 1'b1 || grant_id !== 2'b01 || m_adr !== 32'h500) begin
      failures++; $display("FAIL rb_fresh_grant got req=%b gid=%b adr=%h exp 1/01/500", m_req, grant_id, m_adr);
    end
    m_ack = 1'b1; m_rdata = 32'h5A5A5A5A;
    @(negedge clk);
    m_ack = 1'b0; i_read_req = 1'b0;
    checks++;
    if (read_valid !== 1'b1 || read_data !== 32'h5A5A5A5A) begin
      failures++; $display("FAIL rb_fresh_done got rv=%b rd=%h exp 1/5a5a5a5a", read_valid, read_data);
    end
  endtask

  initial begin
    rst = 1'b1;
    i_read_req = 0; i_read_w = 0; i_read_hw = 0; i_read_adr = '0;
    d_read_req = 0; d_read_w = 0; d_read_hw = 0; d_read_adr = '0;
    d_write_req = 0; d_write_w = 0; d_write_hw = 0; d_write_adr = '0; d_write_data = '0;
    m_ack = 0; m_rdata = '0;
    @(negedge clk);
    test_reset();
    test_single_fetch();
    test_write_then_read();
    test_starvation();
    test_timeout();
    test_ack_last_cycle();
    test_reset_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Single-port memory bus arbiter between the CPU's instruction-fetch read, data read and data write requesters and one shared memory port. It selects one requester at a time and drives the shared port until that transaction completes. It then returns completion (`read_valid`/`read_data` or `write_finish`) to the requesters. It sits between the CPU top-level memory request ports and the memory/bus controller, and adds starvation protection for fetch and an acknowledge timeout.

## Interface
- `ACK_TIMEOUT`, 255: maximum number of cycles `m_req` is held without `m_ack` (range 2..255, 8-bit counter).
- `STARVE_LIMIT`, 4: number of consecutive data grants with fetch pending before fetch is forced to win (range 1..15).
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `i_read_req`, `i_read_w`, `i_read_hw`  in  1 each  fetch request (level, held until completion), word size, half-word size.
- `i_read_adr`  in  32  fetch byte address.
- `d_read_req`, `d_read_w`, `d_read_hw`  in  1 each  data-read request, word size, half-word size.
- `d_read_adr`  in  32  data-read address.
- `d_write_req`, `d_write_w`, `d_write_hw`  in  1 each  data-write request, word size, half-word size.
- `d_write_adr`, `d_write_data`  in  32 each  data-write address and data.
- `read_valid`  out  1  one-cycle pulse; `read_data` is valid for the granted read.
- `read_data`  out  32  read data, held until the next read completion.
- `write_finish`  out  1  one-cycle pulse; the granted write has completed.
- `bus_err`  out  1  one-cycle pulse, coincident with the completion pulse, on timeout.
- `grant_id`  out  2  current owner: 00 none, 01 fetch, 10 data read, 11 data write.
- `m_req`  out  1  shared-port request, held until ack or timeout.
- `m_we`, `m_w`, `m_hw`  out  1 each  write enable, word size, half-word size.
- `m_adr`, `m_wdata`  out  32 each  address and write data.
- `m_ack`  in  1  one-cycle completion from memory.
- `m_rdata`  in  32  read data, valid with `m_ack`.

## Operation
- The FSM has three states: IDLE, BUSY, DONE.
- IDLE:
  - If any request is high, pick a winner.
  - Register that requester's address, size, data and `m_we` into the `m_*` outputs.
  - Set `m_req`=1 and `grant_id`.
  - Clear the timeout counter and go to BUSY.
  - If no request is high, stay in IDLE.
- Priority: data write > data read > fetch.
  - Exception: when the starvation counter equals `STARVE_LIMIT` and `i_read_req` is high, fetch wins.
- Starvation counter (4-bit):
  - Increments on each data grant made while `i_read_req` is high.
  - Clears on a fetch grant.
  - Saturates at `STARVE_LIMIT`.
- BUSY:
  - `m_*` outputs are frozen.
  - Dropping a request mid-transaction does not abort it.
  - On `m_ack`:
    - Drop `m_req`.
    - For a read, `read_data`<=`m_rdata` and pulse `read_valid`.
    - For a write, pulse `write_finish`.
    - Go to DONE.
  - With no ack, the counter increments. When it reaches `ACK_TIMEOUT`-1 and `m_ack` is still low:
    - Drop `m_req`.
    - Pulse `bus_err` plus the normal completion pulse; reads return `read_data`=0.
    - Go to DONE.
  - `m_ack` in the timeout cycle counts as a normal completion, with no error.
- DONE:
  - Lasts one cycle, so the requester can drop its request.
  - `grant_id`<=00; return to IDLE.
- `m_ack` seen in IDLE or DONE is ignored (late ack after a timeout).
- When `m_ack` is low, `m_rdata` is don't-care.

## Timing
- Reset values (asynchronous): state IDLE; `m_req`, `m_we`, `m_w`, `m_hw`=0; `m_adr`, `m_wdata`, `read_data`=0; `read_valid`, `write_finish`, `bus_err`=0; `grant_id`=00; both counters 0.
- Reset asserted mid-BUSY drops `m_req` immediately. The pending transaction produces no completion.
- A request high in IDLE at cycle n gives `m_req`=1 from cycle n+1.
- `m_ack` at cycle k gives `read_valid`/`write_finish` high in cycle k+1 (DONE). The state is IDLE at k+2.
- Minimum turnaround: request at n, ack at n+1, completion at n+2, next arbitration at n+3.
- On timeout, `m_req` is high for exactly `ACK_TIMEOUT` cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Single fetch: `i_read_req`=1, `i_read_adr`=0x100. Expect `m_req`/`m_adr`=0x100, `m_we`=0. `m_ack` with `m_rdata`=0xDEADBEEF three cycles later gives a `read_valid` pulse, `read_data`=0xDEADBEEF, `grant_id`=01 during BUSY.
- Simultaneous `d_write_req` (0x200, data 0x55) and `d_read_req` (0x204) → write granted first (`m_we`=1, `m_wdata`=0x55), then read. Each gets exactly one completion pulse.
- Starvation with `STARVE_LIMIT`=2: fetch held high while data requests stay continuously pending → grant order data, data, fetch, then data again.
- Timeout with `ACK_TIMEOUT`=8 and no `m_ack` → `m_req` high for 8 cycles, then `bus_err`+`read_valid` with `read_data`=0. A late `m_ack` two cycles later is ignored, so no extra pulse.
- Ack on the final timeout cycle → normal completion, `bus_err` stays 0.
- `rst` asserted during BUSY → `m_req`=0 and all outputs at reset values the same cycle. Fresh request after release is served normally.
